// File: rtl/decode_pkg.sv
// Shared types and the combinational instruction decode for the decode stage.
// Contents:
//   funtype_e   - instruction class (reg / mem / branch / kernel)
//   FC_*        - funcode values that select special behaviour
//   F_*         - bit indices into the 8-bit control flag vector
//   decoded_t   - decoded bundle; imm is carried at IMM_W bits and
//                 truncated by the consumer to its datapath width
//   decode_instr() - pure decode of one instruction word
package decode_pkg;

   localparam int IMM_W = 64;

   typedef enum logic [1:0] {
      FT_REG    = 2'b00,
      FT_MEM    = 2'b01,
      FT_BRANCH = 2'b10,
      FT_KERNEL = 2'b11
   } funtype_e;

   localparam logic [1:0] FC_CMP     = 2'b11;
   localparam logic [1:0] FC_LOAD    = 2'b00;
   localparam logic [1:0] FC_STORE   = 2'b01;
   localparam logic [1:0] FC_CACHEWR = 2'b01;
   localparam logic [1:0] FC_CACHESH = 2'b10;

   localparam int F_WB      = 7;
   localparam int F_MEMRD   = 6;
   localparam int F_MEMWR   = 5;
   localparam int F_CPRS    = 4;
   localparam int F_CACHEWR = 3;
   localparam int F_CACHESH = 2;
   localparam int F_BRANCH  = 1;
   localparam int F_IMM     = 0;

   typedef struct packed {
      funtype_e         funtype;
      logic [1:0]       funcode;
      logic [3:0]       rd;
      logic [3:0]       rs;
      logic [3:0]       rx;
      logic [IMM_W-1:0] imm;
      logic [7:0]       flags;
   } decoded_t;

   function automatic decoded_t decode_instr(input logic [31:0] instr, input logic sext);
      decoded_t   d;
      funtype_e   ft;
      logic [1:0] fc;
      ft = funtype_e'(instr[31:30]);
      fc = instr[29:28];
      d  = '0;
      d.funtype = ft;
      d.funcode = fc;
      d.rd      = instr[27:24];
      d.rs      = instr[23:20];
      d.rx      = instr[19:16];
      d.flags[F_WB]      = (ft == FT_REG && fc != FC_CMP) || (ft == FT_MEM && fc == FC_LOAD) ||
                           (ft == FT_BRANCH) || (ft == FT_KERNEL && !fc[0]);
      d.flags[F_MEMRD]   = (ft == FT_MEM && fc == FC_LOAD);
      d.flags[F_MEMWR]   = (ft == FT_MEM && fc == FC_STORE);
      d.flags[F_CPRS]    = (ft == FT_REG && fc == FC_CMP);
      d.flags[F_CACHEWR] = (ft == FT_KERNEL && fc == FC_CACHEWR);
      d.flags[F_CACHESH] = (ft == FT_KERNEL && fc == FC_CACHESH);
      d.flags[F_BRANCH]  = (ft == FT_BRANCH);
      d.flags[F_IMM]     = instr[0];
      // CMP compares against its RD field, so that field travels on the RS lane
      if (d.flags[F_CPRS]) d.rs = instr[27:24];
      case (ft)
         FT_REG:    d.imm = {{(IMM_W-19){sext & instr[19]}}, instr[19:1]};
         FT_BRANCH: d.imm = {{(IMM_W-28){sext & instr[27]}}, instr[27:0]};
         default:   d.imm = {{(IMM_W-4){sext & instr[23]}}, instr[23:20]};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/decode_if.sv
// Bus between fetch / execute / writeback and the decode stage.
// master: environment side (drives instruction, out_ready, writeback, flush)
// slave : decode stage (drives in_ready, the output bundle and pending)
// pending exposes the register scoreboard for observation only.
interface decode_if #(
   parameter int BUS  = 32,
   parameter int NREG = 16
);
   localparam int RW = $clog2(NREG);

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic            out_valid;
   logic            out_ready;
   logic [1:0]      out_funtype;
   logic [1:0]      out_funcode;
   logic [RW-1:0]   out_rd;
   logic [RW-1:0]   out_rs;
   logic [RW-1:0]   out_rx;
   logic [BUS-1:0]  out_imm;
   logic [7:0]      out_flags;
   logic            wb_valid;
   logic [RW-1:0]   wb_rd;
   logic            flush;
   logic [NREG-1:0] pending;

   modport master (
      output in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
      input  in_ready, out_valid, out_funtype, out_funcode, out_rd, out_rs, out_rx,
             out_imm, out_flags, pending
   );

   modport slave (
      input  in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
      output in_ready, out_valid, out_funtype, out_funcode, out_rd, out_rs, out_rx,
             out_imm, out_flags, pending
   );

endinterface

// File: rtl/reg_scoreboard.sv
// One pending bit per architectural register.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears all bits)
//   set_en, set_addr    mark register as having a write in flight
//   clr_en, clr_addr    writeback retired the register
//   pending             current pending vector
// A set and a clear of the same register in one cycle leaves it set: the
// newly issued writer is younger than the one retiring.
module reg_scoreboard #(
   parameter int NREG = 16,
   localparam int RW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_en,
   input  logic [RW-1:0]   set_addr,
   input  logic            clr_en,
   input  logic [RW-1:0]   clr_addr,
   output logic [NREG-1:0] pending
);

   logic [NREG-1:0] pending_nxt;

   always_comb begin
      pending_nxt = pending;
      if (clr_en) pending_nxt[clr_addr] = 1'b0;
      if (set_en) pending_nxt[set_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= pending_nxt;
   end

endmodule

// File: rtl/decode_stage.sv
// Registered, flow-controlled instruction decode stage with RAW-hazard stall.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus (slave)  fetch handshake (in_*), output bundle handshake (out_*),
//                writeback retire (wb_valid/wb_rd), flush, pending vector
// Parameters: BUS datapath/imm width (28..64), NREG register count (<=16),
// SEXT_IMM selects sign (1) or zero (0) extension of the immediate.
module decode_stage
   import decode_pkg::*;
#(
   parameter int BUS      = 32,
   parameter int NREG     = 16,
   parameter int SEXT_IMM = 0
) (
   input  logic clk,
   input  logic rst_n,
   decode_if.slave bus
);

   localparam int RW = $clog2(NREG);

   decoded_t        dec;
   decoded_t        bundle_q;
   logic            out_valid_q;
   logic [NREG-1:0] pending;
   logic [RW-1:0]   out_rd;
   logic [RW-1:0]   src_a;
   logic [RW-1:0]   src_b;
   logic [RW-1:0]   src_d;
   logic            reads_rx;
   logic            reads_rd;
   logic            inflight_wb;
   logic            hazard;
   logic            accept;
   logic            issue;
   logic            unused_bundle;

   assign dec = decode_instr(bus.in_instr, SEXT_IMM != 0);

   // Sources come from the raw fields; dec.rs is remapped for CMP.
   assign src_a    = bus.in_instr[20 +: RW];
   assign src_b    = bus.in_instr[16 +: RW];
   assign src_d    = bus.in_instr[24 +: RW];
   assign reads_rx = (dec.funtype == FT_REG) && !dec.flags[F_IMM];
   assign reads_rd = dec.flags[F_MEMWR] || dec.flags[F_CPRS];

   assign out_rd = bundle_q.rd[RW-1:0];

   // The bundle sitting in the output register has not set its pending bit yet.
   // Branch writeback goes to the PC, so it never blocks a GPR read.
   assign inflight_wb = out_valid_q && bundle_q.flags[F_WB] && !bundle_q.flags[F_BRANCH];

   function automatic logic busy(input logic [RW-1:0] a, input logic [NREG-1:0] pend,
                                 input logic infl, input logic [RW-1:0] infl_rd);
      return pend[a] || (infl && (a == infl_rd));
   endfunction

   assign hazard = busy(src_a, pending, inflight_wb, out_rd) ||
                   (reads_rx && busy(src_b, pending, inflight_wb, out_rd)) ||
                   (reads_rd && busy(src_d, pending, inflight_wb, out_rd));

   assign bus.in_ready = (!out_valid_q || bus.out_ready) && !(bus.in_valid && hazard) && !bus.flush;
   assign accept       = bus.in_valid && bus.in_ready;
   assign issue        = out_valid_q && bus.out_ready && !bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         bundle_q    <= dec;
      end else if (bus.out_ready || bus.flush) begin
         out_valid_q <= 1'b0;
      end
   end

   reg_scoreboard #(.NREG(NREG)) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue && bundle_q.flags[F_WB] && !bundle_q.flags[F_BRANCH]),
      .set_addr (out_rd),
      .clr_en   (bus.wb_valid),
      .clr_addr (bus.wb_rd),
      .pending  (pending)
   );

   assign bus.out_valid   = out_valid_q;
   assign bus.out_funtype = bundle_q.funtype;
   assign bus.out_funcode = bundle_q.funcode;
   assign bus.out_rd      = out_rd;
   assign bus.out_rs      = bundle_q.rs[RW-1:0];
   assign bus.out_rx      = bundle_q.rx[RW-1:0];
   assign bus.out_imm     = bundle_q.imm[BUS-1:0];
   assign bus.out_flags   = bundle_q.flags;
   assign bus.pending     = pending;

   // Upper imm bits beyond BUS and register bits beyond RW are not exported.
   assign unused_bundle = ^bundle_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed sequences plus a randomized phase.
// Accepted instructions are decoded by the package function into a queue;
// every drained bundle is popped and compared. A second instance with
// sign extension enabled covers the immediate extension option.
module tb_decode_stage;
   import decode_pkg::*;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;
   decoded_t exp_q[$];

   decode_if #(.BUS(32), .NREG(16)) vif ();
   decode_if #(.BUS(32), .NREG(16)) vs ();

   decode_stage #(.BUS(32), .NREG(16), .SEXT_IMM(0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(vif.slave));
   decode_stage #(.BUS(32), .NREG(16), .SEXT_IMM(1)) dut_sext (
      .clk(clk), .rst_n(rst_n), .bus(vs.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard monitor: pop on drain (discard on flush), push on accept.
   always @(negedge clk) begin
      decoded_t e;
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (vif.out_valid && vif.flush) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
         end else if (vif.out_valid && vif.out_ready) begin
            chk("q_has_entry", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("out_fields",
                   64'({vif.out_funtype, vif.out_funcode, vif.out_rd, vif.out_rs, vif.out_rx, vif.out_flags}),
                   64'({e.funtype, e.funcode, e.rd, e.rs, e.rx, e.flags}));
               chk("out_imm", 64'(vif.out_imm), 64'(e.imm[31:0]));
            end
         end
         if (vif.in_valid && vif.in_ready) exp_q.push_back(decode_instr(vif.in_instr, 1'b0));
      end
   end

   task automatic send(input logic [31:0] instr);
      int n;
      @(posedge clk); #1;
      vif.in_valid = 1'b1;
      vif.in_instr = instr;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!vif.in_ready && n < 50);
      chk("send_accept", 64'(vif.in_ready), 64'(1));
      @(posedge clk); #1;
      vif.in_valid = 1'b0;
   endtask

   task automatic retire(input logic [3:0] r);
      @(posedge clk); #1;
      vif.wb_valid = 1'b1;
      vif.wb_rd    = r;
      @(posedge clk); #1;
      vif.wb_valid = 1'b0;
   endtask

   initial begin
      int  sent;
      logic acc;
      n_chk = 0;
      n_pass = 0;
      rst_n = 1'b0;
      vif.in_valid = 0; vif.in_instr = '0; vif.out_ready = 1; vif.wb_valid = 0; vif.wb_rd = '0; vif.flush = 0;
      vs.in_valid  = 0; vs.in_instr  = '0; vs.out_ready  = 1; vs.wb_valid  = 0; vs.wb_rd  = '0; vs.flush  = 0;
      #12;
      chk("rst_out_valid", 64'(vif.out_valid), 64'(0));
      chk("rst_pending", 64'(vif.pending), 64'(0));
      chk("rst_flags", 64'(vif.out_flags), 64'(0));
      chk("rst_imm", 64'(vif.out_imm), 64'(0));
      chk("rst_rd", 64'(vif.out_rd), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 64'(vif.in_ready), 64'(1));

      // ADD r3,r1,r2
      send(32'h0312_0000);
      @(negedge clk);
      chk("add_valid", 64'(vif.out_valid), 64'(1));
      chk("add_regs", 64'({vif.out_rd, vif.out_rs, vif.out_rx}), 64'(12'h312));
      chk("add_flags", 64'(vif.out_flags), 64'(8'h80));
      @(negedge clk);
      chk("add_pending", 64'(vif.pending), 64'(16'h0008));
      chk("add_drained", 64'(vif.out_valid), 64'(0));
      retire(4'd3);
      @(negedge clk);
      chk("add_retired", 64'(vif.pending), 64'(0));

      // CMP r5,r6
      send(32'h3560_0000);
      @(negedge clk);
      chk("cmp_rs", 64'(vif.out_rs), 64'(5));
      chk("cmp_flags", 64'(vif.out_flags), 64'(8'h10));
      @(negedge clk);
      chk("cmp_no_pending", 64'(vif.pending), 64'(0));

      // issue-set and writeback-clear of r3 in the same cycle
      send(32'h0312_0000);
      vif.wb_valid = 1'b1;
      vif.wb_rd    = 4'd3;
      @(negedge clk);
      @(posedge clk); #1;
      vif.wb_valid = 1'b0;
      @(negedge clk);
      chk("set_wins", 64'(vif.pending), 64'(16'h0008));
      retire(4'd3);
      @(negedge clk);
      chk("set_wins_retired", 64'(vif.pending), 64'(0));

      // ADD r3 then SUB r4,r3,r1 back-to-back
      send(32'h0312_0000);
      vif.in_valid = 1'b1;
      vif.in_instr = 32'h1431_0000;
      @(negedge clk);
      chk("raw_inflight", 64'(vif.in_ready), 64'(0));
      @(negedge clk);
      chk("raw_pending", 64'(vif.in_ready), 64'(0));
      @(posedge clk); #1;
      vif.wb_valid = 1'b1;
      vif.wb_rd    = 4'd3;
      @(negedge clk);
      chk("raw_nobypass", 64'(vif.in_ready), 64'(0));
      @(posedge clk); #1;
      vif.wb_valid = 1'b0;
      @(negedge clk);
      chk("raw_release", 64'(vif.in_ready), 64'(1));
      @(posedge clk); #1;
      vif.in_valid = 1'b0;
      @(negedge clk);
      chk("sub_out_rd", 64'(vif.out_rd), 64'(4));
      retire(4'd4);
      @(negedge clk);
      chk("sub_retired", 64'(vif.pending), 64'(0));

      // branch, zero-extended here and sign-extended on the second instance
      send(32'h8ABC_DEF0);
      @(negedge clk);
      chk("br_imm_zext", 64'(vif.out_imm), 64'(32'h0ABC_DEF0));
      chk("br_flags", 64'(vif.out_flags), 64'(8'h82));
      @(negedge clk);
      chk("br_no_pending", 64'(vif.pending), 64'(0));
      @(posedge clk); #1;
      vs.in_valid = 1'b1;
      vs.in_instr = 32'h8ABC_DEF0;
      @(negedge clk);
      chk("sext_in_ready", 64'(vs.in_ready), 64'(1));
      @(posedge clk); #1;
      vs.in_valid = 1'b0;
      @(negedge clk);
      chk("br_imm_sext", 64'(vs.out_imm), 64'(32'hFABC_DEF0));
      chk("sext_flags", 64'(vs.out_flags), 64'(8'h82));
      @(negedge clk);
      chk("sext_no_pending", 64'(vs.pending), 64'(0));

      // output stall with a second instruction waiting
      @(posedge clk); #1;
      vif.out_ready = 1'b0;
      send(32'hD123_0000);
      vif.in_valid = 1'b1;
      vif.in_instr = 32'hE456_0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(vif.in_ready), 64'(0));
         chk("stall_hold", 64'({vif.out_rd, vif.out_flags, vif.out_imm}), 64'({4'd1, 8'h08, 32'd2}));
      end
      @(posedge clk); #1;
      vif.out_ready = 1'b1;
      @(negedge clk);
      chk("stall_swap", 64'(vif.in_ready), 64'(1));
      @(posedge clk); #1;
      vif.in_valid = 1'b0;
      @(negedge clk);
      chk("stall_second", 64'({vif.out_rd, vif.out_flags}), 64'({4'd4, 8'h84}));
      retire(4'd4);

      // flush while a bundle is held
      @(posedge clk); #1;
      vif.out_ready = 1'b0;
      send(32'h0712_0000);
      vif.flush     = 1'b1;
      vif.out_ready = 1'b1;
      vif.in_valid  = 1'b1;
      vif.in_instr  = 32'h3560_0000;
      @(negedge clk);
      chk("flush_blocks", 64'(vif.in_ready), 64'(0));
      @(posedge clk); #1;
      vif.flush = 1'b0;
      @(negedge clk);
      chk("flush_cleared", 64'({vif.out_valid, vif.pending}), 64'(0));
      chk("flush_next_ready", 64'(vif.in_ready), 64'(1));
      @(posedge clk); #1;
      vif.in_valid = 1'b0;
      @(negedge clk);

      // async reset mid-stall with a pending register
      send(32'h0912_0000);
      @(posedge clk); #1;
      vif.out_ready = 1'b0;
      send(32'h0312_0000);
      vif.in_valid = 1'b1;
      vif.in_instr = 32'h3560_0000;
      @(negedge clk);
      chk("pre_rst_pending", 64'(vif.pending), 64'(16'h0200));
      chk("pre_rst_stall", 64'(vif.in_ready), 64'(0));
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(vif.out_valid), 64'(0));
      chk("rst_mid_pending", 64'(vif.pending), 64'(0));
      chk("rst_mid_rd", 64'(vif.out_rd), 64'(0));
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      vif.out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 64'(vif.in_ready), 64'(1));
      @(posedge clk); #1;
      vif.in_valid = 1'b0;
      @(negedge clk);

      // randomized traffic, writeback sweeping all registers
      sent = 0;
      for (int c = 0; c < 1500 && sent < 40; c++) begin
         @(negedge clk);
         acc = vif.in_valid && vif.in_ready;
         @(posedge clk); #1;
         if (acc) sent++;
         if (!vif.in_valid || acc) begin
            vif.in_valid = ($urandom_range(0, 3) != 0) && (sent < 40);
            vif.in_instr = $urandom();
         end
         vif.out_ready = ($urandom_range(0, 3) != 0);
         vif.wb_valid  = 1'b1;
         vif.wb_rd     = 4'(c);
      end
      chk("rand_all_sent", 64'(sent), 64'(40));
      vif.in_valid  = 1'b0;
      vif.out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         vif.wb_rd = 4'(c);
      end
      vif.wb_valid = 1'b0;
      @(negedge clk);
      chk("final_q_empty", 64'(exp_q.size()), 64'(0));
      chk("final_pending", 64'(vif.pending), 64'(0));
      chk("final_out_valid", 64'(vif.out_valid), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
